md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port E_MDOp, input, 4 bits: E-stage multiply/divide operation code (package encoding).
REQ-004 SHALL have port E_A, input, 32 bits: forwarded rs operand.
REQ-005 SHALL have port E_B, input, 32 bits: forwarded rt operand.
REQ-006 SHALL have port E_MDData, output, 32 bits: HI/LO read data, consumed by the E/M pipeline register.
REQ-007 SHALL have port E_Busy, output, 1 bit: registered flag, high while an operation is in flight.
REQ-008 SHALL have port E_Start, output, 1 bit: combinational flag, high when E_MDOp is MULT, MULTU, DIV or DIVU; the hazard unit stalls on E_Start | E_Busy.

Function
REQ-009 SHALL hold internal 32-bit registers HI and LO, a 4-bit down-counter, and latched operands and operation.
REQ-010 SHALL accept a start (E_Start=1, E_Busy=0) at a rising edge, latch E_A, E_B and the operation, load the counter, and set E_Busy=1.
REQ-011 SHALL use latency N=5 for MULT/MULTU and N=10 for DIV/DIVU: E_Busy is high for exactly N cycles after the start edge.
REQ-012 SHALL write HI/LO on the Nth edge after the start and clear E_Busy on that same edge; the result is readable in the following cycle.
REQ-013 SHALL ignore E_Start while E_Busy=1; the in-flight operation and its latched operands are unaffected.
REQ-014 SHALL compute MULT as a signed 64-bit product and MULTU as an unsigned 64-bit product, writing HI=[63:32] and LO=[31:0].
REQ-015 SHALL compute DIV as signed: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
REQ-016 SHALL compute DIVU as unsigned: LO=quotient, HI=remainder.
REQ-017 SHALL handle DIV 0x80000000 / 0xFFFFFFFF by writing LO=0x80000000 and HI=0.
REQ-018 SHALL handle a divisor of 0 (DIV or DIVU) by holding busy for the full 10 cycles and then leaving HI and LO unchanged.
REQ-019 SHALL write HI=E_A on MTHI and LO=E_A on MTLO at the edge, but only when E_Busy=0; when E_Busy=1 the write is ignored.
REQ-020 SHALL drive E_MDData combinationally: HI for MFHI, LO for MFLO, 0 for any other op; MFHI/MFLO during busy return the current (old) HI/LO.
REQ-021 SHALL treat NONE and undefined codes as no-ops.

Reset
REQ-022 SHALL, while reset=0, asynchronously force HI=0, LO=0, counter=0, E_Busy=0 and clear the latched operands and operation.
REQ-023 SHALL, on reset asserted mid-operation, discard the pending result with no HI/LO write; E_MDData then reads 0.

Structure
REQ-024 SHALL place the op encodings NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8 and the latency constants MULT_CYCLES=5, DIV_CYCLES=10 in the shared package used by the controller.
REQ-025 SHALL be a single module with no sub-modules; the arithmetic SHALL be computed combinationally from the latched operands and committed when the counter expires.

Verification
REQ-026 SHALL verify MULT with A=0xFFFFFFFF, B=2: E_Busy high 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-027 SHALL verify MULTU with A=0xFFFFFFFF, B=2: HI=0x00000001 and LO=0xFFFFFFFE after 5 cycles.
REQ-028 SHALL verify DIV with A=-7, B=2: E_Busy high 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with A=7, B=0 then leaves HI/LO unchanged after 10 cycles.
REQ-029 SHALL verify that MTHI 0x1234 and a second MULT issued during busy are both ignored, and that MFLO during busy returns the old LO.
REQ-030 SHALL verify reset=0 asserted in cycle 4 of a DIV: E_Busy drops immediately, HI=LO=0, and there is no late write after reset is released.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and
// the number of cycles each arithmetic class keeps the unit busy.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers. Operands are latched at
// start; the result is computed from the latched copy and committed on expiry.
module md_unit
    import md_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic [31:0] E_MDData,
    output logic        E_Busy,
    output logic        E_Start
);

    logic        busy_r;
    logic [3:0]  cnt_r;
    logic [3:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        start_s;
    logic        is_mult_s;
    logic        res_we_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic [63:0] prod_s;
    logic [31:0] div_b_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;

    // Decode the incoming op into start and multiply-class flags.
    always_comb begin
        start_s   = 1'b0;
        is_mult_s = 1'b0;
        case (E_MDOp)
            MD_MULT, MD_MULTU: begin
                start_s   = 1'b1;
                is_mult_s = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                start_s   = 1'b1;
                is_mult_s = 1'b0;
            end
            default: begin
                start_s   = 1'b0;
                is_mult_s = 1'b0;
            end
        endcase
    end

    // Result datapath from latched operands. A zero divisor is replaced by 1
    // only to keep the dividers defined; such a result is never written.
    always_comb begin
        div_b_s  = (b_r == 32'd0) ? 32'd1 : b_r;
        abs_a_s  = a_r[31] ? (32'd0 - a_r) : a_r;
        abs_b_s  = div_b_s[31] ? (32'd0 - div_b_s) : div_b_s;
        sq_s     = abs_a_s / abs_b_s;
        sr_s     = abs_a_s % abs_b_s;
        uq_s     = a_r / div_b_s;
        ur_s     = a_r % div_b_s;
        prod_s   = 64'd0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_we_s = 1'b0;
        case (op_r)
            MD_MULT: begin
                // Low 64 bits of the product of sign-extended operands is the signed product.
                prod_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_we_s = 1'b1;
            end
            MD_MULTU: begin
                prod_s   = {32'd0, a_r} * {32'd0, b_r};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_we_s = 1'b1;
            end
            MD_DIV: begin
                res_lo_s = (a_r[31] ^ b_r[31]) ? (32'd0 - sq_s) : sq_s;
                res_hi_s = a_r[31] ? (32'd0 - sr_s) : sr_s;
                res_we_s = (b_r != 32'd0);
            end
            MD_DIVU: begin
                res_lo_s = uq_s;
                res_hi_s = ur_s;
                res_we_s = (b_r != 32'd0);
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
                res_we_s = 1'b0;
            end
        endcase
    end

    // Controller: countdown while busy, otherwise accept starts and HI/LO moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            cnt_r  <= 4'd0;
            op_r   <= 4'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else if (busy_r) begin
            if (cnt_r == 4'd1) begin
                busy_r <= 1'b0;
                cnt_r  <= 4'd0;
                if (res_we_s) begin
                    hi_r <= res_hi_s;
                    lo_r <= res_lo_s;
                end
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end else if (start_s) begin
            a_r    <= E_A;
            b_r    <= E_B;
            op_r   <= E_MDOp;
            busy_r <= 1'b1;
            cnt_r  <= is_mult_s ? MULT_CYCLES : DIV_CYCLES;
        end else if (E_MDOp == MD_MTHI) begin
            hi_r <= E_A;
        end else if (E_MDOp == MD_MTLO) begin
            lo_r <= E_A;
        end
    end

    // Read mux for MFHI/MFLO; reads during busy see the committed values.
    always_comb begin
        case (E_MDOp)
            MD_MFHI: E_MDData = hi_r;
            MD_MFLO: E_MDData = lo_r;
            default: E_MDData = 32'd0;
        endcase
    end

    assign E_Busy  = busy_r;
    assign E_Start = start_s;

endmodule
